// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port (CPU/DMA) arbiter in front of a single-port data RAM
//
// Purpose:
//   Grants one of two requesters per cycle onto a single-port RAM. Port 0 (CPU)
//   has priority; port 1 (DMA) wins when it is alone or once it has been held
//   off for MAX_WAIT consecutive cycles. Responses come back one cycle after
//   the grant and are routed by a registered owner tag.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   mN_req/we/wstrb/addr/wdata  request and attributes from port N (N = 0, 1)
//   mN_gnt                      combinational accept of port N's request
//   mN_rdata, mN_rvalid         response to port N, one cycle after its grant
//   ram_ce/we/wstrb/addr/wdata  RAM command for the granted port
//   ram_rdata, ram_rdata_valid  RAM read data, valid one cycle after ram_ce

module ram_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [3:0]            m0_wstrb,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_rvalid,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [3:0]            m1_wstrb,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_rvalid,

  output logic                  ram_ce,
  output logic                  ram_we,
  output logic [3:0]            ram_wstrb,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic                  ram_rdata_valid
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  owner_t     owner;
  logic [7:0] wait_cnt;
  logic       m1_wins;

  // Grants are qualified by rst_n so nothing reaches the RAM while in reset.
  always_comb begin
    m1_wins   = m1_req && (!m0_req || (wait_cnt == WAIT_LIMIT));
    m0_gnt    = rst_n && m0_req && !m1_wins;
    m1_gnt    = rst_n && m1_wins;
    ram_ce    = m0_gnt || m1_gnt;
    ram_we    = 1'b0;
    ram_wstrb = 4'b0000;
    ram_addr  = m0_addr;
    ram_wdata = m0_wdata;
    if (m1_gnt) begin
      ram_we    = m1_we;
      ram_wstrb = m1_wstrb;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
    end else if (m0_gnt) begin
      ram_we    = m0_we;
      ram_wstrb = m0_wstrb;
    end
  end

  // Owner tags the access in flight so the next-cycle RAM data is routed to
  // the port that issued it; an untagged response is simply dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner    <= OWN_NONE;
      wait_cnt <= 8'd0;
    end else begin
      if (m0_gnt) begin
        owner <= OWN_P0;
      end else if (m1_gnt) begin
        owner <= OWN_P1;
      end else begin
        owner <= OWN_NONE;
      end

      if (!m1_req || m1_gnt) begin
        wait_cnt <= 8'd0;
      end else if (wait_cnt < WAIT_LIMIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  assign m0_rvalid = rst_n && ram_rdata_valid && (owner == OWN_P0);
  assign m1_rvalid = rst_n && ram_rdata_valid && (owner == OWN_P1);
  assign m0_rdata  = (owner == OWN_P0) ? ram_rdata : '0;
  assign m1_rdata  = (owner == OWN_P1) ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with a behavioural RAM

module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [11:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce, ram_we;
  logic [3:0]  ram_wstrb;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;
  logic        model_valid = 1'b0;
  logic        inject = 1'b0;
  logic        ram_rdata_valid;
  logic        init_done = 1'b0;
  logic [31:0] mem [0:4095];

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q [$];

  always #5 clk = ~clk;

  assign ram_rdata_valid = model_valid | inject;

  ram_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_wstrb(ram_wstrb), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_rdata_valid(ram_rdata_valid)
  );

  // Single-port RAM: read-before-write, data one cycle after ram_ce.
  always @(posedge clk) begin
    if (!init_done) begin
      mem[12'h001] <= 32'h11111111;
      mem[12'h002] <= 32'h22222222;
      mem[12'h005] <= 32'hDEADBEEF;
      mem[12'h010] <= 32'hAAAAAAAA;
      init_done    <= 1'b1;
    end else if (ram_ce) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_wstrb[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
    end
    model_valid <= ram_ce;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_m0(input logic r, input logic w, input logic [3:0] s,
                        input logic [11:0] a, input logic [31:0] d);
    m0_req = r; m0_we = w; m0_wstrb = s; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic r, input logic w, input logic [3:0] s,
                        input logic [11:0] a, input logic [31:0] d);
    m1_req = r; m1_we = w; m1_wstrb = s; m1_addr = a; m1_wdata = d;
  endtask

  // One clock: check grant/RAM command mid-cycle, queue the expected response.
  task automatic step(input logic eg0, input logic eg1, input logic push,
                      input logic [31:0] edata, input string nm);
    #3;
    chk({nm, ".m0_gnt"}, 32'(m0_gnt), 32'(eg0));
    chk({nm, ".m1_gnt"}, 32'(m1_gnt), 32'(eg1));
    chk({nm, ".ram_ce"}, 32'(ram_ce), 32'(eg0 | eg1));
    if (eg1) begin
      chk({nm, ".ram_addr"}, 32'(ram_addr), 32'(m1_addr));
      chk({nm, ".ram_we"}, 32'(ram_we), 32'(m1_we));
    end else if (eg0) begin
      chk({nm, ".ram_addr"}, 32'(ram_addr), 32'(m0_addr));
      chk({nm, ".ram_we"}, 32'(ram_we), 32'(m0_we));
    end else begin
      chk({nm, ".ram_we_idle"}, 32'(ram_we), 32'h0);
      chk({nm, ".ram_wstrb_idle"}, 32'(ram_wstrb), 32'h0);
    end
    if (!rst_n) begin
      chk({nm, ".rvalid_in_reset"}, 32'({m1_rvalid, m0_rvalid}), 32'h0);
    end
    if (push) exp_q.push_back({eg1, edata});
    @(posedge clk);
    #1;
  endtask

  task automatic contend(input int n, input string nm);
    set_m0(1'b1, 1'b0, 4'h0, 12'h001, 32'h0);
    set_m1(1'b1, 1'b0, 4'h0, 12'h002, 32'h0);
    for (int i = 0; i < n; i++) begin
      if (i % 9 == 8) step(1'b0, 1'b1, 1'b1, 32'h22222222, nm);
      else            step(1'b1, 1'b0, 1'b1, 32'h11111111, nm);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_m0(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
    set_m1(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);

    // Response monitor: pops the scoreboard whenever a port presents rvalid.
    fork
      forever begin
        logic [32:0] e;
        @(negedge clk);
        if (m0_rvalid || m1_rvalid) begin
          if (m0_rvalid && m1_rvalid) begin
            chk("both_rvalid", 32'h3, 32'h1);
          end else if (exp_q.size() == 0) begin
            chk("unexpected_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("resp_port", 32'(m1_rvalid), 32'(e[32]));
            chk("resp_data", m1_rvalid ? m1_rdata : m0_rdata, e[31:0]);
            chk("idle_port_rdata", m1_rvalid ? m0_rdata : m1_rdata, 32'h0);
          end
        end
      end
    join_none

    @(posedge clk);
    #1;
    // Reset with both ports requesting: nothing may be granted.
    set_m0(1'b1, 1'b0, 4'h0, 12'h005, 32'h0);
    set_m1(1'b1, 1'b0, 4'h0, 12'h002, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, "reset0");
    step(1'b0, 1'b0, 1'b0, 32'h0, "reset1");

    // First cycle out of reset: m0 read of 0x005.
    rst_n = 1'b1;
    set_m1(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, "m0_rd_005");

    // Partial write from m1 returns the old word; m0 then reads the merge.
    set_m0(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
    set_m1(1'b1, 1'b1, 4'b0011, 12'h010, 32'h12345678);
    step(1'b0, 1'b1, 1'b1, 32'hAAAAAAAA, "m1_wr_010");
    set_m1(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
    set_m0(1'b1, 1'b0, 4'h0, 12'h010, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'hAAAA5678, "m0_rd_010");

    // Alternating single-port reads, back to back.
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        set_m1(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        set_m0(1'b1, 1'b0, 4'h0, 12'h001, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h11111111, "alt_m0");
      end else begin
        set_m0(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        set_m1(1'b1, 1'b0, 4'h0, 12'h002, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h22222222, "alt_m1");
      end
    end

    // Continuous contention: 8 m0 grants then one m1 grant, twice.
    contend(18, "starve");

    // m1 starves 5 cycles, drops for one, then must wait a full 8 again.
    contend(5, "pre_drop");
    set_m1(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h11111111, "m1_dropped");
    contend(9, "after_drop");

    // Stray RAM valid with no owner must not surface on either port.
    set_m0(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
    set_m1(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, "idle");
    inject = 1'b1;
    #3;
    chk("stray_valid_dropped", 32'({m1_rvalid, m0_rvalid}), 32'h0);
    @(posedge clk);
    #1;
    inject = 1'b0;

    // m1 read in flight when reset hits: the response must vanish.
    set_m1(1'b1, 1'b0, 4'h0, 12'h002, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, "m1_before_reset");
    rst_n = 1'b0;
    set_m0(1'b1, 1'b0, 4'h0, 12'h001, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, "mid_reset");
    rst_n = 1'b1;
    contend(9, "post_reset");

    set_m0(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
    set_m1(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, "drain0");
    step(1'b0, 1'b0, 1'b0, 32'h0, "drain1");
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
